// File: rtl/des_sched_pkg.sv
// Shared widths and state encodings for the DES region scheduler and its worker slices.
package des_sched_pkg;

    localparam int REGION_W = 4;
    localparam int CNT_W    = 10;

    typedef enum logic [2:0] {
        W_IDLE,
        W_CLR,
        W_RUN,
        W_DRAIN,
        W_HOLD
    } worker_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_RUN,
        T_DONE
    } top_state_t;

endpackage

// File: rtl/des_sched_worker.sv
// One worker slice: owns a region through clear, timed run, drain and hold-for-collection.
module des_sched_worker
    import des_sched_pkg::*;
#(
    parameter int RUN_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_kill,
    input  logic                i_dispatch,
    input  logic [REGION_W-1:0] i_region,
    input  logic                i_collect,
    input  logic                i_valid,
    output logic                o_idle,
    output logic                o_hold,
    output logic                o_clear,
    output logic                o_start,
    output logic [REGION_W-1:0] o_region
);

    localparam int              RC_W     = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
    localparam logic [RC_W-1:0] RUN_LAST = RC_W'(RUN_CYCLES - 1);

    worker_state_t       r_state;
    worker_state_t       w_next;
    logic [RC_W-1:0]     r_run_cnt;
    logic [REGION_W-1:0] r_region;

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= W_IDLE;
            r_run_cnt <= '0;
            r_region  <= '0;
        end else begin
            r_state   <= w_next;
            r_run_cnt <= (r_state == W_RUN && w_next == W_RUN) ? r_run_cnt + RC_W'(1) : '0;
            if (i_dispatch) r_region <= i_region;
        end
    end

    // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        if (i_kill) begin
            w_next = W_IDLE;
        end else begin
            case (r_state)
                W_IDLE:  if (i_dispatch) w_next = W_CLR;
                W_CLR:   w_next = W_RUN;
                W_RUN:   if (r_run_cnt == RUN_LAST) w_next = W_DRAIN;
                W_DRAIN: if (i_valid) w_next = W_HOLD;
                W_HOLD:  if (i_collect) w_next = W_IDLE;
                default: w_next = W_IDLE;
            endcase
        end
    end

    assign o_idle   = (r_state == W_IDLE);
    assign o_hold   = (r_state == W_HOLD);
    assign o_clear  = (r_state == W_CLR);
    assign o_start  = (r_state == W_RUN);
    assign o_region = r_region;

endmodule

// File: rtl/des_region_scheduler.sv
// Campaign controller: dispatches regions to a des_block pool, collects and sums their counters.
// Optional per-region result log enabled by defining DES_SCHED_LOG_EN.
module des_region_scheduler
    import des_sched_pkg::*;
#(
    parameter int NUM_WORKERS = 2,
    parameter int NUM_REGIONS = 16,
    parameter int RUN_CYCLES  = 1024,
    parameter int ACC_W       = 14
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            go,
    input  logic                            abort,
    output logic                            busy,
    output logic                            done,
    output logic [ACC_W-1:0]                total_count,
    output logic [4:0]                      regions_done,
    output logic [NUM_WORKERS-1:0]          w_rst_n,
    output logic [NUM_WORKERS-1:0]          w_start,
    output logic [REGION_W*NUM_WORKERS-1:0] w_region,
    input  logic [NUM_WORKERS-1:0]          w_valid,
    input  logic [CNT_W*NUM_WORKERS-1:0]    w_counter
`ifdef DES_SCHED_LOG_EN
    ,
    input  logic [REGION_W-1:0]             log_addr,
    output logic [CNT_W-1:0]                log_data
`endif
);

    localparam int               SUM_W      = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX    = '1;
    localparam logic [4:0]       REGION_END = 5'(NUM_REGIONS);

    top_state_t             r_state;
    top_state_t             w_next_state;
    logic [4:0]             r_next_region;
    logic [ACC_W-1:0]       r_total;
    logic [4:0]             r_regions_done;

    logic [NUM_WORKERS-1:0] w_idle;
    logic [NUM_WORKERS-1:0] w_hold;
    logic [NUM_WORKERS-1:0] w_clear;
    logic [NUM_WORKERS-1:0] w_disp_oh;
    logic [NUM_WORKERS-1:0] w_coll_oh;
    logic                   w_run;
    logic                   w_kill;
    logic                   w_accept_go;
    logic                   w_can_dispatch;
    logic                   w_collect;
    logic                   w_last_collect;
    logic [CNT_W-1:0]       w_coll_cnt;
    logic [SUM_W-1:0]       w_sum;
    logic [ACC_W-1:0]       w_total_next;

    assign w_run          = (r_state == T_RUN);
    assign w_kill         = w_run && abort;
    assign w_accept_go    = (r_state != T_RUN) && go && !abort;
    assign w_can_dispatch = w_run && !abort && (r_next_region < REGION_END);

    // x & -x isolates the lowest set bit: lowest-index idle/holding worker wins.
    assign w_disp_oh      = w_can_dispatch ? (w_idle & (~w_idle + NUM_WORKERS'(1))) : '0;
    assign w_coll_oh      = (w_run && !abort) ? (w_hold & (~w_hold + NUM_WORKERS'(1))) : '0;
    assign w_collect      = |w_coll_oh;
    assign w_last_collect = w_collect && (r_regions_done + 5'd1 == REGION_END);

    always_comb begin
        w_coll_cnt = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            if (w_coll_oh[i]) w_coll_cnt = w_counter[CNT_W*i +: CNT_W];
        end
    end

    assign w_sum        = SUM_W'(r_total) + SUM_W'(w_coll_cnt);
    assign w_total_next = (w_sum > SUM_W'(ACC_MAX)) ? ACC_MAX : w_sum[ACC_W-1:0];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            T_IDLE, T_DONE: if (w_accept_go) w_next_state = T_RUN;
            T_RUN: begin
                if (abort)               w_next_state = T_IDLE;
                else if (w_last_collect) w_next_state = T_DONE;
            end
            default: w_next_state = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= T_IDLE;
            r_next_region  <= '0;
            r_total        <= '0;
            r_regions_done <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept_go) begin
                r_next_region  <= '0;
                r_total        <= '0;
                r_regions_done <= '0;
            end else begin
                if (|w_disp_oh) r_next_region <= r_next_region + 5'd1;
                if (w_collect) begin
                    r_total        <= w_total_next;
                    r_regions_done <= r_regions_done + 5'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_WORKERS; g++) begin : g_worker
        des_sched_worker #(
            .RUN_CYCLES (RUN_CYCLES)
        ) u_worker (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_kill     (w_kill),
            .i_dispatch (w_disp_oh[g]),
            .i_region   (r_next_region[REGION_W-1:0]),
            .i_collect  (w_coll_oh[g]),
            .i_valid    (w_valid[g]),
            .o_idle     (w_idle[g]),
            .o_hold     (w_hold[g]),
            .o_clear    (w_clear[g]),
            .o_start    (w_start[g]),
            .o_region   (w_region[REGION_W*g +: REGION_W])
        );
    end

    assign w_rst_n      = {NUM_WORKERS{rst_n}} & ~w_clear;
    assign busy         = w_run;
    assign done         = (r_state == T_DONE);
    assign total_count  = r_total;
    assign regions_done = r_regions_done;

`ifdef DES_SCHED_LOG_EN
    localparam int LOG_DEPTH = 1 << REGION_W;

    logic [REGION_W-1:0] w_coll_region;
    logic [CNT_W-1:0]    r_log_mem [LOG_DEPTH];
    logic [CNT_W-1:0]    r_log_data;

    always_comb begin
        w_coll_region = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            if (w_coll_oh[i]) w_coll_region = w_region[REGION_W*i +: REGION_W];
        end
    end

    // NOTE: the log must read as zero after reset or go, so it is a cleared flop array, not a RAM macro.
    always_ff @(posedge clk) begin
        if (!rst_n || w_accept_go) begin
            for (int i = 0; i < LOG_DEPTH; i++) r_log_mem[i] <= '0;
        end else if (w_collect) begin
            r_log_mem[w_coll_region] <= w_coll_cnt;
        end
        if (!rst_n) r_log_data <= '0;
        else        r_log_data <= r_log_mem[log_addr];
    end

    assign log_data = r_log_data;
`endif

endmodule
